instr_mem_responder: RTL and testbench

Memory-side responder for the instruction fetch interface (`instr_req`/`instr_gnt`/`instr_valid`): accepts fetch requests, grants them subject to an outstanding-request limit, and returns read data in order after a fixed latency. It is word-addressed, with a side-band program port for loading code. It sits opposite the IF stage in core-level simulation and FPGA bring-up, replacing the program memory.

---
 rtl/instr_mem_responder.sv | 151 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: program-memory stand-in for the instruction fetch port.
// It grants fetch requests up to an outstanding limit and answers them in order
// after a fixed latency. A side-band program port loads the memory contents.
// Optional feature macro: INSTR_MEM_RANDOM_STALL_EN. When it is defined, an LFSR
// withholds the grant on about a quarter of the cycles.
module instr_mem_responder #(
    parameter int          MEM_DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               instr_req,
    input  logic [31:0]                        instr_addr,
    output logic                               instr_gnt,
    output logic [31:0]                        instr_rdata,
    output logic                               instr_err,
    output logic                               instr_valid,
    input  logic                               prog_we,
    input  logic [$clog2(MEM_DEPTH)-1:0]       prog_addr,
    input  logic [31:0]                        prog_wdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int          AW   = $clog2(MEM_DEPTH);
    localparam int          OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] SPAN = 32'(4 * MEM_DEPTH);

    // Catch illegal configurations at elaboration time.
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("instr_mem_responder: LATENCY must be 1..8");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_max_out
        $error("instr_mem_responder: MAX_OUTSTANDING must be 1..LATENCY+1");
    end
    if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_mem_responder: MEM_DEPTH must be a power of two >= 2");
    end
    if (STALL_SEED == 16'h0000) begin : g_bad_seed
        $error("instr_mem_responder: STALL_SEED must be non-zero");
    end

    logic [31:0]   mem [MEM_DEPTH];

    logic [31:0]   addr_off;
    logic          in_range;
    logic [AW-1:0] rd_idx;
    logic          stall;
    logic          gnt;

    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] eff_out;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [31:0]        data_q [LATENCY];
    logic [31:0]        data_d [LATENCY];

`ifdef INSTR_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR with taps 16,14,13,11. It advances every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register. Reset reloads the seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Decode the byte address into a word index and check it against the window.
    // The window check is done on the offset, so a window that ends at the top of
    // the address space does not wrap around.
    always_comb begin
        addr_off = instr_addr - BASE_ADDR;
        in_range = (instr_addr >= BASE_ADDR) && (addr_off < SPAN);
        rd_idx   = addr_off[AW+1:2];
    end

    // Grant decision. A response retiring this cycle frees its slot immediately.
    always_comb begin
        eff_out = out_q - OW'(vld_q[LATENCY-1]);
        gnt     = instr_req & ~reset & (eff_out < OW'(MAX_OUTSTANDING)) & ~stall;
        out_d   = out_q;
        case ({gnt, vld_q[LATENCY-1]})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    // Response pipeline. Stage 0 is loaded in the grant cycle and later stages
    // shift by one each cycle. Empty slots carry zero data and error so that the
    // outputs read as zero whenever no response is valid.
    always_comb begin
        vld_d[0]  = gnt;
        err_d[0]  = gnt & ~in_range;
        data_d[0] = (gnt && in_range) ? mem[rd_idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // Control and pipeline registers. Reset drops every in-flight response.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= 32'h0;
            end
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Program-port write. This memory is read-first: a grant to the word being
    // written in the same cycle captures the old contents. Reset does not clear it.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign instr_gnt   = gnt;
    assign instr_valid = vld_q[LATENCY-1];
    assign instr_err   = err_q[LATENCY-1];
    assign instr_rdata = data_q[LATENCY-1];
    assign outstanding = out_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Testbench for instr_mem_responder.
// It applies directed and $urandom stimulus and compares the DUT every cycle
// against a transaction-level model: a shadow memory plus a queue of expected
// responses, each tagged with the cycle in which it is due.
module tb_instr_mem_responder;

    localparam int          MEM_DEPTH = 256;
    localparam logic [31:0] BASE      = 32'h0000_2000;
    localparam int          LAT       = 3;
    localparam int          MAXO      = 2;
    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam int          OW        = $clog2(MAXO + 1);
    localparam logic [31:0] TOP       = BASE + 32'(4 * MEM_DEPTH);

    logic          clk;
    logic          reset;
    logic          instr_req;
    logic [31:0]   instr_addr;
    logic          instr_gnt;
    logic [31:0]   instr_rdata;
    logic          instr_err;
    logic          instr_valid;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_wdata;
    logic [OW-1:0] outstanding;

    instr_mem_responder #(
        .MEM_DEPTH       (MEM_DEPTH),
        .BASE_ADDR       (BASE),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO),
        .STALL_SEED      (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_gnt   (instr_gnt),
        .instr_rdata (instr_rdata),
        .instr_err   (instr_err),
        .instr_valid (instr_valid),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .outstanding (outstanding)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] shadow [MEM_DEPTH];
    int          cyc;
    int          n_tests;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Reference decode: returns the shadow word inside the window, or error outside it.
    task automatic lookup(input logic [31:0] a, output logic [31:0] d, output logic e);
        longint unsigned la;
        longint unsigned lb;
        la = longint'(a);
        lb = longint'(BASE);
        if (la >= lb && la < lb + 4 * MEM_DEPTH) begin
            d = shadow[int'((la - lb) / 4)];
            e = 1'b0;
        end else begin
            d = 32'h0;
            e = 1'b1;
        end
    endtask

    // Runs one clock cycle: drive the inputs, check the outputs on the falling
    // edge, then advance the model to match the next rising edge.
    task automatic step(input logic r, input logic rq, input logic [31:0] a,
                        input logic we, input logic [AW-1:0] pa, input logic [31:0] pd,
                        output logic took);
        logic        ev;
        logic        permit;
        int          eo;
        logic [31:0] d;
        logic        e;
        @(posedge clk);
        cyc++;
        #1;
        reset      = r;
        instr_req  = rq;
        instr_addr = a;
        prog_we    = we;
        prog_addr  = pa;
        prog_wdata = pd;
        @(negedge clk);
        eo     = exp_q.size();
        ev     = (eo > 0) && (exp_q[0].due == cyc);
        permit = !r && rq && ((eo - int'(ev)) < MAXO);
`ifdef INSTR_MEM_RANDOM_STALL_EN
        check("gnt_beyond_limit", 32'(instr_gnt & ~permit), 32'h0);
        took = instr_gnt;
`else
        check("gnt", 32'(instr_gnt), 32'(permit));
        took = permit;
`endif
        check("valid", 32'(instr_valid), 32'(ev));
        check("outstanding", 32'(outstanding), 32'(eo));
        if (ev) begin
            check("rdata", instr_rdata, exp_q[0].data);
            check("err", 32'(instr_err), 32'(exp_q[0].err));
        end else begin
            check("rdata_idle", instr_rdata, 32'h0);
            check("err_idle", 32'(instr_err), 32'h0);
        end
        if (r) begin
            exp_q.delete();
        end else begin
            if (ev) void'(exp_q.pop_front());
            if (took) begin
                lookup(a, d, e);
                exp_q.push_back('{due: cyc + LAT, data: d, err: e});
            end
        end
        if (we) shadow[pa] = pd;
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0, g);
    endtask

    initial begin
        logic        g;
        logic [31:0] bnd [6];
        logic [31:0] ra;
        int          k;
        cyc        = 0;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = 32'h0;

        // Hold reset while preloading the memory. Requests must not be granted.
        for (int i = 0; i < MEM_DEPTH; i++) begin
            step(1'b1, 1'b1, BASE, 1'b1, AW'(i), (i == 0) ? 32'h0000_0013 : $urandom, g);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 32'h0, g);

        // Single fetch of word 0.
        step(1'b0, 1'b1, BASE, 1'b0, '0, 32'h0, g);
        idle(LAT + 1);

        // Window edges. Low address bits are ignored.
        bnd[0] = TOP - 32'd4;
        bnd[1] = TOP;
        bnd[2] = BASE - 32'd4;
        bnd[3] = BASE + 32'd3;
        bnd[4] = TOP - 32'd1;
        bnd[5] = 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, bnd[i], 1'b0, '0, 32'h0, g);
            idle(LAT);
        end

        // Continuous requests, each held until it is granted.
        k = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, BASE + 32'(4 * k), 1'b0, '0, 32'h0, g);
            if (g) k++;
        end
        idle(LAT + 1);

        // Program write colliding with a grant to the same word, then a re-read.
        step(1'b0, 1'b1, BASE + 32'h14, 1'b1, AW'(5), 32'hDEAD_BEEF, g);
        idle(LAT);
        step(1'b0, 1'b1, BASE + 32'h14, 1'b0, '0, 32'h0, g);
        idle(LAT + 1);

        // Reset while two responses are in flight.
        step(1'b0, 1'b1, BASE, 1'b0, '0, 32'h0, g);
        step(1'b0, 1'b1, BASE + 32'h4, 1'b0, '0, 32'h0, g);
        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 32'h0, g);
        idle(LAT + 4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = $urandom;
                1:       ra = (TOP - 32'd8) + 32'($urandom_range(0, 15));
                2:       ra = (BASE - 32'd8) + 32'($urandom_range(0, 15));
                default: ra = BASE + 32'($urandom_range(0, 4 * MEM_DEPTH - 1));
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), ra,
                 ($urandom_range(0, 7) == 0), AW'($urandom), $urandom, g);
        end
        idle(LAT + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
